// File: rtl/spi_transaction_arbiter_pkg.sv
//-----------------------------------------------------------------------------
// spi_arb_pkg
//
// Shared definitions for the SPI transaction arbiter:
//   arb_state_t : arbiter FSM state encoding
//   calc_wait() : completion-window length, saturated to the counter width
//-----------------------------------------------------------------------------
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RESPOND = 2'd3
  } arb_state_t;

  // Window = len*cycles_per_bit + overhead, clamped to 2^wait_width-1.
  // The arithmetic is done at 64 bits, which covers every legal combination
  // of an 8..32-bit length field and a counter of up to 32 bits, so the
  // clamp is applied to the true value and never to a wrapped one.
  function automatic logic [63:0] calc_wait(
    input logic [63:0] len,
    input logic [63:0] cycles_per_bit,
    input logic [63:0] overhead,
    input int          wait_width
  );
    logic [63:0] raw;
    logic [63:0] limit;
    raw   = (len * cycles_per_bit) + overhead;
    limit = (64'd1 << wait_width) - 64'd1;
    return (raw > limit) ? limit : raw;
  endfunction

endpackage : spi_arb_pkg

// File: rtl/spi_transaction_arbiter_if.sv
//-----------------------------------------------------------------------------
// spi_transaction_arbiter_if
//
// Bundles the requester-side handshake and the SPI-master-side transaction
// bus of the arbiter.
//   modport slave  : the arbiter's view (takes requests, drives the SPI master)
//   modport master : the environment's view (requesters + SPI master)
//
// Signals:
//   req_valid/req_ready          per-requester handshake (ready is one-hot)
//   req_length/req_data/req_rw_mask  packed payloads, requester i in slice i
//   rsp_valid/rsp_data           one-hot completion strobe + read word
//   transaction_length/_data/_rw_mask  to the SPI master
//   transaction_read_data        from the SPI master
//   busy/grant_id                status
//-----------------------------------------------------------------------------
interface spi_transaction_arbiter_if #(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ*TRANSACTION_LEN_WIDTH-1:0] req_length;
  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data;
  logic [NUM_REQ*DATA_WIDTH-1:0]            req_rw_mask;
  logic [NUM_REQ-1:0]                       rsp_valid;
  logic [DATA_WIDTH-1:0]                    rsp_data;
  logic [TRANSACTION_LEN_WIDTH-1:0]         transaction_length;
  logic [DATA_WIDTH-1:0]                    transaction_data;
  logic [DATA_WIDTH-1:0]                    transaction_rw_mask;
  logic [DATA_WIDTH-1:0]                    transaction_read_data;
  logic                                     busy;
  logic [ID_W-1:0]                          grant_id;

  modport slave (
    input  req_valid,
    input  req_length,
    input  req_data,
    input  req_rw_mask,
    input  transaction_read_data,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output transaction_length,
    output transaction_data,
    output transaction_rw_mask,
    output busy,
    output grant_id
  );

  modport master (
    output req_valid,
    output req_length,
    output req_data,
    output req_rw_mask,
    output transaction_read_data,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  transaction_length,
    input  transaction_data,
    input  transaction_rw_mask,
    input  busy,
    input  grant_id
  );

endinterface : spi_transaction_arbiter_if

// File: rtl/spi_transaction_arbiter_rr.sv
//-----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin selector: the first asserted request
// found when scanning upward from ptr (wrapping at NUM_REQ) wins.
//
// Ports:
//   req          in  NUM_REQ  request vector
//   ptr          in  IDX_W    index with highest priority this cycle
//   grant_onehot out NUM_REQ  one-hot winner (all zero when nothing requested)
//   grant_idx    out IDX_W    binary index of the winner (0 when none)
//   any          out 1        at least one request present
//-----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // Scan order: w_cand[0] is ptr itself, w_cand[k] is ptr+k modulo NUM_REQ.
  logic [IDX_W-1:0] w_cand [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = IDX_W'((int'(ptr) + k) % NUM_REQ);
    end
  end

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[w_cand[k]]) begin
        any                     = 1'b1;
        grant_onehot[w_cand[k]] = 1'b1;
        grant_idx               = w_cand[k];
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/spi_transaction_arbiter.sv
//-----------------------------------------------------------------------------
// spi_transaction_arbiter
//
// Shares one SPI master among NUM_REQ requesters. One request is accepted
// per transaction (round-robin), issued to the SPI master as a single-cycle
// transaction_length pulse, then the arbiter waits a fixed completion window
// before returning the captured read word as a one-cycle rsp_valid strobe.
// Zero-length requests skip the SPI master and respond with a zero word.
//
// Ports:
//   fabric_clk  in  single clock
//   reset_n     in  asynchronous active-low reset (shared with the SPI master)
//   bus         slave modport of spi_transaction_arbiter_if (see that file)
//-----------------------------------------------------------------------------
module spi_transaction_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ               = 4,
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 8,
  parameter int CYCLES_PER_BIT        = 8,
  parameter int OVERHEAD_CYCLES       = 32,
  parameter int WAIT_WIDTH            = 16
) (
  input  logic                      fabric_clk,
  input  logic                      reset_n,
  spi_transaction_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int LW   = TRANSACTION_LEN_WIDTH;
  localparam int DW   = DATA_WIDTH;

  arb_state_t      r_state;
  arb_state_t      w_next_state;

  logic [NUM_REQ-1:0] w_grant_onehot;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any;
  logic               w_accept;

  logic [LW-1:0]      w_sel_length;
  logic [DW-1:0]      w_sel_data;
  logic [DW-1:0]      w_sel_mask;

  logic [LW-1:0]         r_length;
  logic [DW-1:0]         r_data;
  logic [DW-1:0]         r_mask;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [WAIT_WIDTH-1:0] r_wait_cnt;
  logic [DW-1:0]         r_rsp_data;

  logic w_wait_last;

  //---------------------------------------------------------------------------
  // Round-robin selection among the currently valid requests
  //---------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req          (bus.req_valid),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  assign w_accept     = (r_state == ARB_IDLE) && w_any;
  assign w_sel_length = bus.req_length [int'(w_grant_idx)*LW +: LW];
  assign w_sel_data   = bus.req_data   [int'(w_grant_idx)*DW +: DW];
  assign w_sel_mask   = bus.req_rw_mask[int'(w_grant_idx)*DW +: DW];

  // The counter holds the number of WAIT cycles still to run including the
  // current one, so the last WAIT cycle is the one where it reads 1. The
  // "<= 1" also keeps a degenerate zero-length window from stalling.
  assign w_wait_last = (r_wait_cnt <= WAIT_WIDTH'(1));

  //---------------------------------------------------------------------------
  // FSM: state register
  //---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //---------------------------------------------------------------------------
  // FSM: next-state logic
  //---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_accept) begin
          w_next_state = (w_sel_length != '0) ? ARB_ISSUE : ARB_RESPOND;
        end
      end
      ARB_ISSUE: begin
        w_next_state = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (w_wait_last) begin
          w_next_state = ARB_RESPOND;
        end
      end
      ARB_RESPOND: begin
        w_next_state = ARB_IDLE;
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  //---------------------------------------------------------------------------
  // FSM: outputs
  //---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready          = '0;
    bus.rsp_valid          = '0;
    bus.transaction_length = '0;
    bus.busy               = 1'b1;
    unique case (r_state)
      ARB_IDLE: begin
        bus.busy      = 1'b0;
        // Winner already qualified by its own req_valid inside rr_arbiter.
        bus.req_ready = w_grant_onehot;
      end
      ARB_ISSUE: begin
        // Only state with a nonzero length: exactly one SPI transaction/grant.
        bus.transaction_length = r_length;
      end
      ARB_WAIT: begin
        bus.transaction_length = '0;
      end
      ARB_RESPOND: begin
        bus.rsp_valid[r_grant_id] = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.rsp_data            = r_rsp_data;
  assign bus.transaction_data    = r_data;
  assign bus.transaction_rw_mask = r_mask;
  assign bus.grant_id            = r_grant_id;

  //---------------------------------------------------------------------------
  // Payload latches, round-robin pointer, completion counter, read capture
  //---------------------------------------------------------------------------
  // NOTE: these are individual registers (no memory array), and each one has
  // a visible reset value on the ports, so all of them are reset.
  always_ff @(posedge fabric_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_length   <= '0;
      r_data     <= '0;
      r_mask     <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
      r_rsp_data <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_length   <= w_sel_length;
            r_data     <= w_sel_data;
            r_mask     <= w_sel_mask;
            r_grant_id <= w_grant_idx;
            r_rr_ptr   <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                             : w_grant_idx + 1'b1;
            // Zero-length requests never touch the SPI master; respond with 0.
            if (w_sel_length == '0) begin
              r_rsp_data <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          r_wait_cnt <= WAIT_WIDTH'(calc_wait(64'(r_length),
                                              64'(CYCLES_PER_BIT),
                                              64'(OVERHEAD_CYCLES),
                                              WAIT_WIDTH));
        end
        ARB_WAIT: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
          if (w_wait_last) begin
            r_rsp_data <= bus.transaction_read_data;
          end
        end
        default: begin
          // RESPOND: nothing to update; rsp_data already holds the word.
        end
      endcase
    end
  end

endmodule : spi_transaction_arbiter

// File: tb/tb_spi_transaction_arbiter.sv
//-----------------------------------------------------------------------------
// tb_spi_transaction_arbiter
//
// Scoreboard bench. The stimulus side predicts the grant order for each
// batch of requests from the round-robin rule and pushes the expected
// transactions; a monitor pops and compares on every accept, SPI issue and
// response. A second instance with CYCLES_PER_BIT=512 runs the saturated
// completion window in parallel.
//-----------------------------------------------------------------------------
module tb_spi_transaction_arbiter;

  localparam int NR      = 4;
  localparam int DW      = 32;
  localparam int LW      = 8;
  localparam int CPB     = 8;
  localparam int OH      = 32;
  localparam int WW      = 16;
  localparam int SAT_CPB = 512;

  typedef struct {
    int            id;
    logic [LW-1:0] len;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [DW-1:0] rd;
  } txn_t;

  typedef struct {
    txn_t   t;
    longint acc_cyc;
  } fly_t;

  logic   clk       = 1'b0;
  logic   rst_n     = 1'b0;
  logic   sat_rst_n = 1'b0;
  longint cyc       = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  int            model_ptr = 0;
  logic [DW-1:0] dev_reg   = '0;
  logic [LW-1:0] p_len  [NR];
  logic [DW-1:0] p_data [NR];
  logic [DW-1:0] p_mask [NR];

  txn_t exp_q[$];
  fly_t fly_q[$];
  int   cur_pulses = 0;
  bit   sat_done   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_transaction_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW)) bus ();
  spi_transaction_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW)) sbus ();

  spi_transaction_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW),
    .CYCLES_PER_BIT(CPB), .OVERHEAD_CYCLES(OH), .WAIT_WIDTH(WW)
  ) dut (
    .fabric_clk (clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  spi_transaction_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW),
    .CYCLES_PER_BIT(SAT_CPB), .OVERHEAD_CYCLES(OH), .WAIT_WIDTH(WW)
  ) dut_sat (
    .fabric_clk (clk),
    .reset_n    (sat_rst_n),
    .bus        (sbus)
  );

  // SPI slave device: write bits echo the written data, read bits come from
  // the device register.
  assign bus.transaction_read_data = (bus.transaction_data & bus.transaction_rw_mask)
                                   | (dev_reg & ~bus.transaction_rw_mask);

  //---------------------------------------------------------------------------
  // Helpers
  //---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Accept-to-response distance in cycles.
  function automatic longint exp_latency(input logic [LW-1:0] len, input int cpb);
    longint w;
    if (len == '0) return 1;
    w = longint'(len) * cpb + OH;
    if (w > 65535) w = 65535;
    return w + 2;
  endfunction

  // Grant order of a batch held until served: repeatedly the first pending
  // index at or after the pointer, pointer then moves past the winner.
  function automatic void predict(input logic [NR-1:0] set);
    logic [NR-1:0] rem;
    int   win;
    txn_t t;
    rem = set;
    while (rem != '0) begin
      win = -1;
      for (int k = 0; k < NR; k++) begin
        if (win < 0 && rem[(model_ptr + k) % NR]) win = (model_ptr + k) % NR;
      end
      t.id   = win;
      t.len  = p_len[win];
      t.data = p_data[win];
      t.mask = p_mask[win];
      t.rd   = (p_len[win] == '0) ? '0 : ((p_data[win] & p_mask[win]) | (dev_reg & ~p_mask[win]));
      exp_q.push_back(t);
      rem[win]  = 1'b0;
      model_ptr = (win + 1) % NR;
    end
  endfunction

  task automatic drive_payloads();
    for (int i = 0; i < NR; i++) begin
      bus.req_length [i*LW +: LW] = p_len[i];
      bus.req_data   [i*DW +: DW] = p_data[i];
      bus.req_rw_mask[i*DW +: DW] = p_mask[i];
    end
  endtask

  task automatic rand_payload(input int i, input int max_len);
    p_len[i]  = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, max_len));
    p_data[i] = $urandom;
    p_mask[i] = $urandom;
  endtask

  // Raise a batch of requests, drop each one when accepted, and wait until
  // every predicted transaction has responded.
  task automatic run_round(input logic [NR-1:0] set);
    logic [NR-1:0] acc;
    int guard;
    predict(set);
    drive_payloads();
    bus.req_valid = set;
    guard = 0;
    while ((bus.req_valid != '0 || exp_q.size() != 0 || fly_q.size() != 0) && guard < 20000) begin
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~acc;
      guard++;
    end
    if (guard >= 20000) begin
      fail_now("round_timeout");
      bus.req_valid = '0;
      exp_q.delete();
      fly_q.delete();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_grant_id"}, bus.grant_id, 0);
    check({tag, "_txn_len"}, bus.transaction_length, 0);
    check({tag, "_txn_data"}, bus.transaction_data, 0);
    check({tag, "_txn_mask"}, bus.transaction_rw_mask, 0);
  endtask

  //---------------------------------------------------------------------------
  // Monitor / scoreboard
  //---------------------------------------------------------------------------
  always @(negedge clk) begin
    int   idx;
    txn_t t;
    fly_t f;
    if (rst_n) begin
      if (bus.busy) check("ready_low_while_busy", bus.req_ready, 0);

      if (bus.req_ready != '0) begin
        idx = 0;
        for (int k = 0; k < NR; k++) if (bus.req_ready[k]) idx = k;
        check("ready_onehot", $countones(bus.req_ready), 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_accept");
        end else begin
          t = exp_q.pop_front();
          check("grant_order", idx, t.id);
          f.t        = t;
          f.acc_cyc  = cyc;
          fly_q.push_back(f);
          cur_pulses = 0;
        end
      end

      if (bus.transaction_length != '0) begin
        if (fly_q.size() == 0) begin
          fail_now("unexpected_spi_issue");
        end else begin
          cur_pulses++;
          check("spi_len", bus.transaction_length, fly_q[0].t.len);
          check("spi_data", bus.transaction_data, fly_q[0].t.data);
          check("spi_mask", bus.transaction_rw_mask, fly_q[0].t.mask);
        end
      end

      if (bus.rsp_valid != '0) begin
        if (fly_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          f = fly_q.pop_front();
          check("rsp_onehot", bus.rsp_valid, 64'(1) << f.t.id);
          check("rsp_data", bus.rsp_data, f.t.rd);
          check("rsp_latency", cyc - f.acc_cyc, exp_latency(f.t.len, CPB));
          check("spi_pulses", cur_pulses, (f.t.len != '0) ? 1 : 0);
          check("grant_id", bus.grant_id, f.t.id);
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Saturated completion window on the second instance
  //---------------------------------------------------------------------------
  initial begin
    longint acc_cyc;
    int     guard;
    sbus.req_valid             = '0;
    sbus.req_length            = '0;
    sbus.req_data              = '0;
    sbus.req_rw_mask           = '0;
    sbus.transaction_read_data = 32'h1234_5678;
    wait (sat_rst_n === 1'b1);
    @(posedge clk);
    #1;
    sbus.req_length[LW-1:0] = 8'd255;
    sbus.req_valid          = 4'b0001;
    guard = 0;
    while (sbus.req_ready[0] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    acc_cyc = cyc;
    check("sat_accept", sbus.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    sbus.req_valid = '0;
    guard = 0;
    while (sbus.rsp_valid == '0 && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 70000) begin
      fail_now("sat_rsp_timeout");
    end else begin
      check("sat_latency", cyc - acc_cyc, exp_latency(8'd255, SAT_CPB));
      check("sat_rsp_data", sbus.rsp_data, 32'h1234_5678);
    end
    sat_done = 1'b1;
  end

  //---------------------------------------------------------------------------
  // Main stimulus
  //---------------------------------------------------------------------------
  initial begin
    int guard;
    bus.req_valid   = '0;
    bus.req_length  = '0;
    bus.req_data    = '0;
    bus.req_rw_mask = '0;
    for (int i = 0; i < NR; i++) begin
      p_len[i]  = '0;
      p_data[i] = '0;
      p_mask[i] = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst_n     = 1'b1;
    sat_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: all four held, twice; rotation continues from the pointer.
    for (int r = 0; r < 2; r++) begin
      dev_reg = $urandom;
      for (int i = 0; i < NR; i++) rand_payload(i, 12);
      run_round(4'b1111);
    end

    // Single write.
    dev_reg   = $urandom;
    p_len[0]  = 8'd16;
    p_data[0] = 32'hA5A5_0000;
    p_mask[0] = 32'hFFFF_FFFF;
    run_round(4'b0001);

    // Read back.
    dev_reg   = 32'h0000_005A;
    p_len[1]  = 8'd8;
    p_data[1] = $urandom;
    p_mask[1] = 32'h0000_0000;
    run_round(4'b0010);

    // Zero length.
    dev_reg   = $urandom;
    p_len[2]  = 8'd0;
    p_data[2] = $urandom;
    p_mask[2] = $urandom;
    run_round(4'b0100);

    // Random batches.
    for (int r = 0; r < 12; r++) begin
      dev_reg = $urandom;
      for (int i = 0; i < NR; i++) rand_payload(i, 24);
      run_round(NR'($urandom_range(1, (1 << NR) - 1)));
    end

    // Reset in the middle of WAIT; requester 1 moves the pointer to 2 first.
    dev_reg   = $urandom;
    p_len[1]  = 8'd20;
    p_data[1] = $urandom;
    p_mask[1] = $urandom;
    predict(4'b0010);
    drive_payloads();
    bus.req_valid = 4'b0010;
    guard = 0;
    while (fly_q.size() == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) fail_now("midwait_accept_timeout");
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midwait_busy", bus.busy, 1);
    rst_n = 1'b0;
    fly_q.delete();
    exp_q.delete();
    model_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_values("midwait_reset");
    end
    rst_n = 1'b1;
    // Past the abandoned transaction's response time: any rsp is unexpected.
    repeat (250) @(negedge clk);
    check("post_reset_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    dev_reg = $urandom;
    for (int i = 0; i < NR; i++) rand_payload(i, 10);
    run_round(4'b1111);

    guard = 0;
    while (!sat_done && guard < 80000) begin
      @(posedge clk);
      guard++;
    end
    if (!sat_done) fail_now("sat_done_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_spi_transaction_arbiter
